// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, FSM state type and datapath defaults.
// Imported by the ALU control decoder and the execute unit.
package alu_pkg;

  localparam int ALU_DW  = 32;
  localparam int ALU_SHW = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_NAND = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_ADDU = 4'd4;
  localparam logic [3:0] ALU_SUBU = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_EQ   = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SRAV = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic logic alu_illegal(
    input logic [3:0] op
  );
    return op > ALU_SLTU;
  endfunction

  // Single-cycle evaluation of every op;
  // shifts use a barrel shifter here.
  function automatic logic [ALU_DW-1:0] alu_eval(
    input logic [3:0]         op,
    input logic [ALU_DW-1:0]  a,
    input logic [ALU_DW-1:0]  b,
    input logic [ALU_SHW-1:0] sh
  );
    logic [ALU_DW-1:0] r;
    r = '0;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_NAND: r = ~(a & b);
      ALU_NOR:  r = ~(a | b);
      ALU_ADDU: r = a + b;
      ALU_SUBU: r = a - b;
      ALU_SLT:  r = {{(ALU_DW-1){1'b0}},
                     $signed(a) < $signed(b)};
      ALU_EQ:   r = {{(ALU_DW-1){1'b0}}, a == b};
      ALU_SRA,
      ALU_SRAV: r = $unsigned($signed(b) >>> sh);
      ALU_LUI:  r = {b[15:0], 16'h0};
      ALU_SLTU: r = {{(ALU_DW-1){1'b0}}, a < b};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: issue and result handshake bundle of the execute ALU.
// master = issuing stage / consumer side, slave = alu_exec_unit.
interface alu_exec_unit_if;
  import alu_pkg::*;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [3:0]         alu_ctrl_i;
  logic [ALU_DW-1:0]  src1_i;
  logic [ALU_DW-1:0]  src2_i;
  logic [ALU_SHW-1:0] shamt_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [ALU_DW-1:0]  result_o;
  logic               zero_o;
  logic               illegal_o;
  logic               busy_o;

  modport master (
    output in_valid_i, alu_ctrl_i,
    output src1_i, src2_i, shamt_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  result_o, zero_o,
    input  illegal_o, busy_o
  );

  modport slave (
    input  in_valid_i, alu_ctrl_i,
    input  src1_i, src2_i, shamt_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output result_o, zero_o,
    output illegal_o, busy_o
  );

endinterface

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: 1-bit-per-cycle arithmetic right shifter with down counter.
// Ports: clk_i, rst_i, flush_i, start, data, amount -> result, done.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int SHW = ALU_SHW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           start,
  input  logic [DW-1:0]  data,
  input  logic [SHW-1:0] amount,
  output logic [DW-1:0]  result,
  output logic           done
);

  logic [SHW-1:0] cnt;
  logic [DW-1:0]  sreg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (flush_i) begin
      cnt  <= '0;
    end else if (start) begin
      cnt  <= amount;
      sreg <= data;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      sreg <= {sreg[DW-1], sreg[DW-1:1]};
    end
  end

  // On the last step the final bit is applied
  // combinationally so the result lands on the
  // same edge the counter reaches zero.
  assign result = {sreg[DW-1], sreg[DW-1:1]};
  assign done   = (cnt == {{(SHW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result, zero and illegal flags.
// Ports: clk_i, rst_i, flush_i, bus (slave: issue/result handshake, busy).
// Optional ALU_ITER_SHIFT_EN: SRA/SRAV shift one bit per cycle in SHIFT state.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int SHW = ALU_SHW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  alu_exec_unit_if.slave  bus
);

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic           take;
  logic           is_shift;
  logic           iter_start;
  logic           done;
  logic [SHW-1:0] amt;
  logic [DW-1:0]  comb_res;
  logic [DW-1:0]  shift_res;
  logic           out_valid;
  logic [DW-1:0]  result;
  logic           zero;
  logic           illegal;

  assign bus.in_ready_o = (state == IDLE)
                        & (!out_valid | bus.out_ready_i)
                        & !flush_i;

  assign accept   = bus.in_valid_i & bus.in_ready_o;
  assign take     = out_valid & bus.out_ready_i;
  assign is_shift = (bus.alu_ctrl_i == ALU_SRA)
                  | (bus.alu_ctrl_i == ALU_SRAV);
  assign amt      = (bus.alu_ctrl_i == ALU_SRAV)
                  ? bus.src1_i[SHW-1:0]
                  : bus.shamt_i;
  assign comb_res = alu_eval(bus.alu_ctrl_i,
                             bus.src1_i,
                             bus.src2_i,
                             amt);

`ifdef ALU_ITER_SHIFT_EN
  // A zero amount completes on the accept edge.
  assign iter_start = accept & is_shift
                    & (amt != '0);

  alu_shift_iter #(
    .DW  (DW),
    .SHW (SHW)
  ) u_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .start   (iter_start),
    .data    (bus.src2_i),
    .amount  (amt),
    .result  (shift_res),
    .done    (done)
  );

  assign bus.busy_o = (state == SHIFT);
`else
  assign iter_start = 1'b0;
  assign done       = 1'b0;
  assign shift_res  = '0;
  assign bus.busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (iter_start) state_next = SHIFT;
      SHIFT: if (done)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept && !iter_start) begin
      out_valid <= 1'b1;
      result    <= comb_res;
      zero      <= (comb_res == '0);
      illegal   <= alu_illegal(bus.alu_ctrl_i);
    end else if (done && state == SHIFT) begin
      out_valid <= 1'b1;
      result    <= shift_res;
      zero      <= (shift_res == '0);
      illegal   <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.result_o    = result;
  assign bus.zero_o      = zero;
  assign bus.illegal_o   = illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit
// against a behavioural model; expectations adapt to ALU_ITER_SHIFT_EN.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sra_ref(
    input logic [31:0] v, input int n);
    if (v[31]) return ~((~v) >> n);
    return v >> n;
  endfunction

  function automatic logic [31:0] model(
    input int op, input logic [31:0] a,
    input logic [31:0] b, input int sh,
    output logic ill);
    ill = 1'b0;
    case (op)
      0:  return a & b;
      1:  return a | b;
      2:  return ~(a & b);
      3:  return ~(a | b);
      4:  return a + b;
      5:  return a - b;
      6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  return (a == b) ? 32'd1 : 32'd0;
      8:  return sra_ref(b, sh);
      9:  return sra_ref(b, int'(a % 32));
      10: return b << 16;
      11: return (a < b) ? 32'd1 : 32'd0;
      default: begin
        ill = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  task automatic drive(input int op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int sh);
    bus.in_valid_i = 1'b1;
    bus.alu_ctrl_i = op[3:0];
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.shamt_i    = sh[4:0];
    #1;
  endtask

  // Issue one op, wait for its result, check value,
  // flags and latency. Leaves the result presented.
  task automatic run_op(input string tag,
                        input int op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int sh);
    logic [31:0] exp;
    logic        ill;
    int          n;
    int          amt;
    int          lat_exp;
    exp = model(op, a, b, sh, ill);
    amt = (op == 9) ? int'(a % 32) : sh;
    lat_exp = (ITER && (op == 8 || op == 9) && amt > 0)
            ? amt + 1 : 1;
    drive(op, a, b, sh);
    n = 0;
    while (!bus.in_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ready_to"}, 32'(n >= 100), 32'd0);
    tick();
    bus.in_valid_i = 1'b0;
    n = 1;
    while (!bus.out_valid_o && n < 80) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    chk({tag, "_lat"}, n, lat_exp);
    chk({tag, "_res"}, bus.result_o, exp);
    chk({tag, "_zero"}, 32'(bus.zero_o),
        32'(exp == 32'd0));
    chk({tag, "_ill"}, 32'(bus.illegal_o), 32'(ill));
  endtask

  initial begin
    int          lat;
    int          bcnt;
    bit          seen;
    int          op;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rs;

    rst             = 1'b1;
    flush           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.alu_ctrl_i  = '0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.shamt_i     = '0;
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_res", bus.result_o, 32'd0);
    chk("rst_zero", 32'(bus.zero_o), 32'd0);
    chk("rst_ill", 32'(bus.illegal_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_ready", 32'(bus.in_ready_o), 32'd1);

    // Reset asserted in the middle of an SRAV by 20.
    drive(9, 32'd20, 32'h8000_00F0, 0);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_res", bus.result_o, 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);

    // Back-to-back issue with the consumer always ready.
    run_op("addu", 4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("subu", 5, 32'd5, 32'd7, 0);
    run_op("slt", 6, 32'h8000_0000, 32'd1, 0);
    run_op("sltu", 11, 32'h8000_0000, 32'd1, 0);
    tick();

    // SRA by 31 of the most negative value.
    drive(8, 32'd0, 32'h8000_0000, 31);
    tick();
    bus.in_valid_i = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!bus.out_valid_o && lat < 80) begin
      if (bus.busy_o) bcnt++;
      tick();
      lat++;
    end
    chk("sra31_lat", lat, ITER ? 32 : 1);
    chk("sra31_busy", bcnt, ITER ? 31 : 0);
    chk("sra31_res", bus.result_o, 32'hFFFF_FFFF);
    chk("sra31_busy_end", 32'(bus.busy_o), 32'd0);
    tick();

    // Backpressure: OR result held, LUI waits.
    bus.out_ready_i = 1'b0;
    drive(1, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    tick();
    drive(10, 32'd0, 32'h0000_1234, 0);
    chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_res", bus.result_o, 32'hF0F0_0F0F);
      chk("bp_hold_rdy", 32'(bus.in_ready_o), 32'd0);
      chk("bp_hold_vld", 32'(bus.out_valid_o), 32'd1);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
    chk("bp_lui_vld", 32'(bus.out_valid_o), 32'd1);
    chk("bp_lui_res", bus.result_o, 32'h1234_0000);
    tick();

    // Flush two cycles into an SRAV by 10.
    bus.out_ready_i = 1'b0;
    drive(9, 32'd10, 32'hF000_0000, 0);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid_o) seen = 1'b1;
      tick();
    end
    chk("fl_no_res", 32'(seen), 32'd0);
    chk("fl_busy", 32'(bus.busy_o), 32'd0);
    chk("fl_idle", 32'(bus.in_ready_o), 32'd1);
    bus.out_ready_i = 1'b1;
    run_op("fl_eq", 7, 32'd3, 32'd3, 0);

    // Illegal code then a legal NOR.
    run_op("ill13", 13, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op("nor", 3, 32'd0, 32'd0, 0);

    // Random ops with a bias toward interesting operands.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      rs = int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) ra = ra % 8;
      run_op("rand", op, ra, rb, rs);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
